// File: rtl/mem_read_arbiter.sv
// Read-port arbiter: one synchronous-read memory shared by NUM_REQ masters.
// Requester 0 has fixed priority, 1..NUM_REQ-1 are round-robin with a starvation guard.
module mem_read_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_data,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd_en,
    input  logic [DATA_W-1:0]         mem_data,
    output logic [2:0]                grant_id
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic              inflight_vld_q, inflight_vld_d;
    logic [IDX_W-1:0]  inflight_idx_q, inflight_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0] wait_q [NUM_REQ];
    logic [WAIT_W-1:0] wait_d [NUM_REQ];

    logic [NUM_REQ-1:0] elig;
    logic               starve_hit, rr_hit, win_vld;
    logic [IDX_W-1:0]   starve_idx, rr_idx, win_idx, cand;
    logic               issue, ret;

    // Position `off` in the rotating order 1..NUM_REQ-1 that starts at ptr.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] ptr, input int off);
        int p;
        p = (int'(ptr) - 1 + off) % (NUM_REQ - 1);
        return IDX_W'(p + 1);
    endfunction

    // A request still in its return cycle is masked so it cannot be issued twice.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && !(inflight_vld_q && (inflight_idx_q == IDX_W'(i)));
        end
    end

    // Scan the rotation backwards so the last hit kept is the first in round-robin order.
    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        rr_hit     = 1'b0;
        rr_idx     = '0;
        cand       = '0;
        for (int off = NUM_REQ - 2; off >= 0; off--) begin
            cand = rot_idx(rr_ptr_q, off);
            if (elig[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
                if (wait_q[cand] == WAIT_MAX) begin
                    starve_hit = 1'b1;
                    starve_idx = cand;
                end
            end
        end
    end

    always_comb begin
        win_vld = 1'b1;
        win_idx = '0;
        if (starve_hit) begin
            win_idx = starve_idx;
        end else if (elig[0]) begin
            win_idx = '0;
        end else if (rr_hit) begin
            win_idx = rr_idx;
        end else begin
            win_vld = 1'b0;
        end
    end

    always_comb begin
        inflight_vld_d = win_vld;
        inflight_idx_d = win_idx;
        rr_ptr_d       = rr_ptr_q;
        if (win_vld && (win_idx != '0)) begin
            rr_ptr_d = (win_idx == LAST_IDX) ? IDX_W'(1) : win_idx + IDX_W'(1);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            wait_d[k] = wait_q[k];
            if (k == 0) begin
                wait_d[k] = '0;
            end else if (!req_valid[k] || (win_vld && (win_idx == IDX_W'(k)))) begin
                wait_d[k] = '0;
            end else if (wait_q[k] != WAIT_MAX) begin
                wait_d[k] = wait_q[k] + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_vld_q <= 1'b0;
            inflight_idx_q <= '0;
            rr_ptr_q       <= IDX_W'(1);
            for (int k = 0; k < NUM_REQ; k++) begin
                wait_q[k] <= '0;
            end
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_idx_q <= inflight_idx_d;
            rr_ptr_q       <= rr_ptr_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                wait_q[k] <= wait_d[k];
            end
        end
    end

    // Gating with RST drops a pending return in the reset cycle and keeps all outputs at 0.
    assign issue = win_vld && !RST;
    assign ret   = inflight_vld_q && !RST;

    always_comb begin
        mem_rd_en = issue;
        mem_addr  = '0;
        grant_id  = 3'd0;
        if (issue) begin
            mem_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            grant_id = 3'(win_idx);
        end
    end

    always_comb begin
        req_ready = '0;
        req_data  = '0;
        if (ret) begin
            req_ready[inflight_idx_q] = 1'b1;
            req_data                  = mem_data;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed tables, corner sequences,
// and randomized masters checked against a queue-based arbitration model.
module tb_mem_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 15;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   req_data;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_en;
    logic [DW-1:0]   mem_data = '0;
    logic [2:0]      grant_id;

    // second instance with a short starvation limit
    logic [N*AW-1:0] s_req_addr = {16'h0303, 16'h0202, 16'h0101, 16'h0000};
    logic [N-1:0]    s_req_valid = '0;
    logic [N-1:0]    s_req_ready;
    logic [DW-1:0]   s_req_data;
    logic [AW-1:0]   s_mem_addr;
    logic            s_mem_rd_en;
    logic [DW-1:0]   s_mem_data = 16'hBEEF;
    logic [2:0]      s_grant_id;

    mem_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .RST(RST), .req_addr(req_addr), .req_valid(req_valid),
        .req_ready(req_ready), .req_data(req_data), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_data(mem_data), .grant_id(grant_id)
    );

    mem_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(2)) dut_s (
        .CLK(CLK), .RST(RST), .req_addr(s_req_addr), .req_valid(s_req_valid),
        .req_ready(s_req_ready), .req_data(s_req_data), .mem_addr(s_mem_addr),
        .mem_rd_en(s_mem_rd_en), .mem_data(s_mem_data), .grant_id(s_grant_id)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [7:0] lo;
        lo = {a[6:0], 1'b0};
        return {lo + 8'd1, lo};
    endfunction

    always @(posedge CLK) begin
        if (mem_rd_en) mem_data <= mem_word(mem_addr);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- masters, model state, scoreboard ----------------
    logic [AW-1:0] m_addr [N];
    logic [N-1:0]  m_valid = '0;
    logic [N-1:0]  saw_rdy = '0;
    int            rate [N] = '{80, 100, 50, 30};
    int            md_inf;
    int            md_rr;
    int            md_wait [N];
    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;

    typedef struct {
        logic [N-1:0] valid;
        logic         exp_rd;
        logic [2:0]   exp_gnt;
        logic [N-1:0] exp_rdy;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = m_addr[i];
        req_valid = m_valid;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        m_valid = '0;
        s_req_valid = '0;
        drive();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        md_inf = -1;
        md_rr = 1;
        for (int k = 0; k < N; k++) md_wait[k] = 0;
        saw_rdy = '0;
    endtask

    // One randomized cycle: masters obey the hold-until-ready protocol, the model
    // predicts the winner, and returned data is matched against the expected queue.
    task automatic rand_cycle(input bit allow_new);
        int cand [$];
        int win;
        for (int i = 0; i < N; i++) begin
            if (saw_rdy[i] || !m_valid[i]) begin
                if (allow_new && ($urandom_range(99) < rate[i])) begin
                    m_valid[i] = 1'b1;
                    m_addr[i]  = 16'($urandom_range(16'hFFFF));
                end else begin
                    m_valid[i] = 1'b0;
                end
            end
        end
        drive();
        @(negedge CLK);

        for (int off = 0; off < N - 1; off++) begin
            int k;
            k = 1 + (md_rr - 1 + off) % (N - 1);
            if (m_valid[k] && k != md_inf) cand.push_back(k);
        end
        win = -1;
        foreach (cand[j]) if (win < 0 && md_wait[cand[j]] == MW) win = cand[j];
        if (win < 0 && m_valid[0] && md_inf != 0) win = 0;
        if (win < 0 && cand.size() > 0) win = cand[0];

        check("rand_rd_en", 32'(mem_rd_en), (win >= 0) ? 32'd1 : 32'd0);
        check("rand_grant", 32'(grant_id), (win >= 0) ? 32'(win) : 32'd0);
        if (win >= 0) check("rand_mem_addr", 32'(mem_addr), 32'(m_addr[win]));
        check("rand_ready", 32'(req_ready), (md_inf >= 0) ? (32'd1 << md_inf) : 32'd0);
        if (req_ready != '0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_ready: got 0x%0h expected none", req_ready);
            end else begin
                check("sb_data", 32'(req_data), 32'(exp_q.pop_front()));
            end
        end
        if (win >= 0) exp_q.push_back(mem_word(m_addr[win]));
        saw_rdy = req_ready;

        for (int k = 1; k < N; k++) begin
            if (!m_valid[k] || win == k) md_wait[k] = 0;
            else if (md_wait[k] < MW) md_wait[k]++;
        end
        if (win >= 1) md_rr = (win == N - 1) ? 1 : win + 1;
        md_inf = win;
        next_cycle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int ri, got;
        int s_exp [7] = '{0, 1, 2, 3, 1, 2, 3};

        tbl[0]  = '{4'b0101, 1'b1, 3'd0, 4'b0000};
        tbl[1]  = '{4'b0101, 1'b1, 3'd2, 4'b0001};
        tbl[2]  = '{4'b0100, 1'b0, 3'd0, 4'b0100};
        tbl[3]  = '{4'b1110, 1'b1, 3'd3, 4'b0000};
        tbl[4]  = '{4'b1110, 1'b1, 3'd1, 4'b1000};
        tbl[5]  = '{4'b1110, 1'b1, 3'd2, 4'b0010};
        tbl[6]  = '{4'b1110, 1'b1, 3'd3, 4'b0100};
        tbl[7]  = '{4'b1110, 1'b1, 3'd1, 4'b1000};
        tbl[8]  = '{4'b1110, 1'b1, 3'd2, 4'b0010};
        tbl[9]  = '{4'b0000, 1'b0, 3'd0, 4'b0100};
        tbl[10] = '{4'b0000, 1'b0, 3'd0, 4'b0000};

        // reset state: outputs held at 0 even with every request raised
        for (int i = 0; i < N; i++) m_addr[i] = 16'h1000 + 16'(i);
        m_valid = '1;
        drive();
        @(negedge CLK);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_data", 32'(req_data), 32'd0);

        // priority then round-robin table
        do_reset();
        for (int r = 0; r < 11; r++) begin
            m_valid = tbl[r].valid;
            drive();
            @(negedge CLK);
            check("tbl_rd_en", 32'(mem_rd_en), 32'(tbl[r].exp_rd));
            check("tbl_grant", 32'(grant_id), 32'(tbl[r].exp_gnt));
            check("tbl_ready", 32'(req_ready), 32'(tbl[r].exp_rdy));
            if (tbl[r].exp_rd) check("tbl_mem_addr", 32'(mem_addr), 32'(16'h1000 + 16'(tbl[r].exp_gnt)));
            if (tbl[r].exp_rdy != '0) begin
                ri = 0;
                for (int b = 0; b < N; b++) if (tbl[r].exp_rdy[b]) ri = b;
                check("tbl_data", 32'(req_data), 32'(mem_word(16'h1000 + 16'(ri))));
            end
            next_cycle();
        end

        // single requester with address advance
        do_reset();
        m_addr[0] = 16'h4000;
        m_valid = 4'b0001;
        drive();
        @(negedge CLK);
        check("single_rd_en_t0", 32'(mem_rd_en), 32'd1);
        check("single_addr_t0", 32'(mem_addr), 32'h4000);
        check("single_grant_t0", 32'(grant_id), 32'd0);
        next_cycle();
        @(negedge CLK);
        check("single_ready_t1", 32'(req_ready), 32'b0001);
        check("single_data_t1", 32'(req_data), 32'h0100);
        check("single_noreissue_t1", 32'(mem_rd_en), 32'd0);
        next_cycle();
        m_addr[0] = 16'h4001;
        drive();
        @(negedge CLK);
        check("single_addr_t2", 32'(mem_addr), 32'h4001);
        check("single_ready_t2", 32'(req_ready), 32'd0);
        next_cycle();
        m_valid = '0;
        drive();
        @(negedge CLK);
        check("single_ready_t3", 32'(req_ready), 32'b0001);
        check("single_data_t3", 32'(req_data), 32'h0302);
        next_cycle();

        // requester 1 must be served within 16 cycles while 0 re-requests
        do_reset();
        m_valid = 4'b0011;
        got = -1;
        for (int c = 0; c < 17 && got < 0; c++) begin
            drive();
            @(negedge CLK);
            if (mem_rd_en && grant_id == 3'd1) got = c;
            next_cycle();
        end
        check("starve_served", (got >= 0 && got <= 16) ? 32'd1 : 32'd0, 32'd1);

        // starvation guard on the MAX_WAIT=2 instance: it overrides requester 0
        do_reset();
        s_req_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            check("sw_rd_en", 32'(s_mem_rd_en), 32'd1);
            check("sw_grant", 32'(s_grant_id), 32'(s_exp[c]));
            check("sw_mem_addr", 32'(s_mem_addr), 32'(16'h0101 * 16'(s_exp[c])));
            if (c > 0) begin
                check("sw_ready", 32'(s_req_ready), 32'd1 << s_exp[c-1]);
                check("sw_data", 32'(s_req_data), 32'hBEEF);
            end
            next_cycle();
        end
        s_req_valid = '0;

        // reset one cycle after a grant to requester 3
        do_reset();
        m_addr[3] = 16'h0123;
        m_valid = 4'b1000;
        drive();
        @(negedge CLK);
        check("mid_grant3", 32'(grant_id), 32'd3);
        next_cycle();
        RST = 1'b1;
        @(negedge CLK);
        check("mid_no_ready", 32'(req_ready), 32'd0);
        check("mid_data0", 32'(req_data), 32'd0);
        check("mid_rd_en0", 32'(mem_rd_en), 32'd0);
        check("mid_addr0", 32'(mem_addr), 32'd0);
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        check("post_no_ready", 32'(req_ready), 32'd0);
        check("post_reissue", 32'(grant_id), 32'd3);
        next_cycle();
        m_valid = '0;
        drive();
        @(negedge CLK);
        check("post_ready3", 32'(req_ready), 32'b1000);
        check("post_data3", 32'(req_data), 32'(mem_word(16'h0123)));
        next_cycle();

        // rr pointer returns to 1 on reset
        do_reset();
        m_valid = 4'b0010;
        drive();
        @(negedge CLK);
        check("rr_pre_grant1", 32'(grant_id), 32'd1);
        next_cycle();
        do_reset();
        m_valid = 4'b0110;
        drive();
        @(negedge CLK);
        check("rr_after_reset", 32'(grant_id), 32'd1);
        next_cycle();

        // randomized traffic against the model, then drain
        do_reset();
        exp_q.delete();
        for (int c = 0; c < 500; c++) rand_cycle(1'b1);
        for (int c = 0; c < 60 && (m_valid != '0 || exp_q.size() != 0); c++) rand_cycle(1'b0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(m_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
